gw2a_ddr_rdlvl: RTL and testbench

//   Read-levelling / word-alignment controller for a bank of Gowin DDR IOBs.
//   - Requests training reads of a fixed 4-bit pattern per lane.
//   - Compares each lane's deserialised IDES4 nibble against the pattern.
//   - Pulses that lane's CALIB (bit-slip) input until the nibble aligns.
//   - Reports per-lane lock, slip counts and overall done/fail to the

---
 rtl/gw2a_ddr_rdlvl.sv | 206 ++++++++++++++++++++
 tb/tb_gw2a_ddr_rdlvl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gw2a_ddr_rdlvl.sv
// gw2a_ddr_rdlvl
//   Read-levelling / word-alignment controller for a bank of Gowin DDR IOBs.
//   Issues training reads, compares each lane's IDES4 nibble against a
//   rotation-unique pattern, and pulses that lane's CALIB (bit-slip) input
//   until the nibble lines up. A lane locks after MATCHES consecutive
//   matching reads. It fails after SLIPS slips without locking.
//
// Ports
//   PCLK        bus clock, shared with the IOBs
//   RESET       synchronous, active-high reset
//   start_i     begin training (taken in IDLE, DONE or FAIL)
//   busy_o      training in progress
//   done_o      all lanes locked (held until RESET or next start)
//   fail_o      lane out of slips or read timeout (held likewise)
//   rd_req_o    training-read request, held until rd_ack_i
//   rd_ack_i    request accepted (same-cycle handshake)
//   rd_valid_i  rd_data_i carries the read beat this cycle
//   rd_data_i   lane n nibble at [4n+3:4n] = {Q3,Q2,Q1,Q0}
//   calib_o     per-lane one-cycle CALIB pulse
//   locked_o    per-lane aligned flag
//   slip_cnt_o  lane n slip count at [3n+2:3n]
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start_i
// REQ    | rd_req_o raised one cycle after entry, waiting for rd_ack_i
// WAIT   | waiting for the read beat; timeout counter running
// CMP    | compare captured nibbles, update match counts and locks
// SLIP   | one-cycle CALIB pulse on the lanes that mismatched
// SETTLE | let the IOB settle after a slip before the next read
// DONE   | every lane locked
// FAIL   | lane exhausted its slips, or a read timed out

module gw2a_ddr_rdlvl #(
  parameter int         WIDTH   = 8,
  parameter logic [3:0] EXPECT  = 4'b0011,
  parameter int         MATCHES = 3,
  parameter int         SLIPS   = 4,
  parameter int         SETTLE  = 8,
  parameter int         TIMEOUT = 64
) (
  input  logic                 PCLK,
  input  logic                 RESET,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 fail_o,
  output logic                 rd_req_o,
  input  logic                 rd_ack_i,
  input  logic                 rd_valid_i,
  input  logic [4*WIDTH-1:0]   rd_data_i,
  output logic [WIDTH-1:0]     calib_o,
  output logic [WIDTH-1:0]     locked_o,
  output logic [3*WIDTH-1:0]   slip_cnt_o
);

  localparam logic [3:0] MATCH_MAX = 4'(MATCHES);
  localparam logic [2:0] SLIP_MAX  = 3'(SLIPS);
  localparam logic [7:0] TMO_LD    = 8'(TIMEOUT);
  localparam logic [7:0] SETTLE_LD = 8'(SETTLE);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_CMP, S_SLIP, S_SETTLE, S_DONE, S_FAIL
  } state_t;

  state_t               state_q, state_d;
  logic                 rd_req_q;
  logic                 done_q, fail_q;
  logic [7:0]           timer_q;
  logic [4*WIDTH-1:0]   data_q;
  logic [WIDTH-1:0]     locked_q, mark_q;
  logic [3:0]           match_q [WIDTH];
  logic [2:0]           slip_q  [WIDTH];

  logic [WIDTH-1:0]     lock_cmp, mark_cmp;
  logic [3:0]           match_cmp [WIDTH];
  logic                 slip_lim;

  // Lane comparison on the captured beat; used only while in CMP.
  // Locked lanes keep their state and are never marked for a slip.
  always_comb begin
    lock_cmp = locked_q;
    mark_cmp = '0;
    slip_lim = 1'b0;
    for (int n = 0; n < WIDTH; n++) begin
      match_cmp[n] = match_q[n];
      if (!locked_q[n]) begin
        if (data_q[4*n +: 4] == EXPECT) begin
          if (match_q[n] != MATCH_MAX) match_cmp[n] = match_q[n] + 4'd1;
          if (match_q[n] >= MATCH_MAX - 4'd1) lock_cmp[n] = 1'b1;
        end else begin
          match_cmp[n] = '0;
          mark_cmp[n]  = 1'b1;
          if (slip_q[n] == SLIP_MAX) slip_lim = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b1;
    calib_o = '0;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        busy_o = 1'b0;
        if (start_i) state_d = S_REQ;
      end
      S_REQ: begin
        if (rd_req_q && rd_ack_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rd_valid_i)              state_d = S_CMP;
        else if (timer_q <= 8'd1)    state_d = S_FAIL;
      end
      S_CMP: begin
        if (&lock_cmp)               state_d = S_DONE;
        else if (slip_lim)           state_d = S_FAIL;
        else if (|mark_cmp)          state_d = S_SLIP;
        else                         state_d = S_REQ;
      end
      S_SLIP: begin
        calib_o = mark_q;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (timer_q <= 8'd1) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      rd_req_q <= 1'b0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
      timer_q  <= '0;
      data_q   <= '0;
      locked_q <= '0;
      mark_q   <= '0;
      for (int n = 0; n < WIDTH; n++) begin
        match_q[n] <= '0;
        slip_q[n]  <= '0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start_i) begin
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
            locked_q <= '0;
            mark_q   <= '0;
            for (int n = 0; n < WIDTH; n++) begin
              match_q[n] <= '0;
              slip_q[n]  <= '0;
            end
          end
        end
        // The request is registered, so it rises one cycle into REQ and an
        // ack is only honoured while it is actually visible on the port.
        S_REQ: begin
          if (rd_req_q && rd_ack_i) begin
            rd_req_q <= 1'b0;
            timer_q  <= TMO_LD;
          end else begin
            rd_req_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (rd_valid_i)           data_q  <= rd_data_i;
          else if (timer_q <= 8'd1) fail_q  <= 1'b1;
          else                      timer_q <= timer_q - 8'd1;
        end
        S_CMP: begin
          locked_q <= lock_cmp;
          mark_q   <= mark_cmp;
          match_q  <= match_cmp;
          if (&lock_cmp)     done_q <= 1'b1;
          else if (slip_lim) fail_q <= 1'b1;
        end
        S_SLIP: begin
          for (int n = 0; n < WIDTH; n++)
            if (mark_q[n] && slip_q[n] != SLIP_MAX) slip_q[n] <= slip_q[n] + 3'd1;
          timer_q <= SETTLE_LD;
        end
        S_SETTLE: begin
          if (timer_q > 8'd1) timer_q <= timer_q - 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign rd_req_o = rd_req_q;
  assign done_o   = done_q;
  assign fail_o   = fail_q;
  assign locked_o = locked_q;

  for (genvar g = 0; g < WIDTH; g++) begin : g_slip
    assign slip_cnt_o[3*g +: 3] = slip_q[g];
  end

endmodule

// File: tb/tb_gw2a_ddr_rdlvl.sv
module tb_gw2a_ddr_rdlvl;

  localparam int         W       = 8;
  localparam logic [3:0] EXP     = 4'b0011;
  localparam int         MATCHES = 3;
  localparam int         SLIPS   = 4;

  logic          PCLK = 1'b0;
  logic          RESET, start_i, rd_ack_i, rd_valid_i;
  logic [4*W-1:0] rd_data_i;
  logic          busy_o, done_o, fail_o, rd_req_o;
  logic [W-1:0]  calib_o, locked_o;
  logic [3*W-1:0] slip_cnt_o;

  always #5 PCLK = ~PCLK;

  gw2a_ddr_rdlvl #(
    .WIDTH(W), .EXPECT(EXP), .MATCHES(MATCHES), .SLIPS(SLIPS),
    .SETTLE(8), .TIMEOUT(64)
  ) dut (
    .PCLK(PCLK), .RESET(RESET), .start_i(start_i), .busy_o(busy_o),
    .done_o(done_o), .fail_o(fail_o), .rd_req_o(rd_req_o),
    .rd_ack_i(rd_ack_i), .rd_valid_i(rd_valid_i), .rd_data_i(rd_data_i),
    .calib_o(calib_o), .locked_o(locked_o), .slip_cnt_o(slip_cnt_o)
  );

  typedef struct {
    string       name;
    int          ack_dly;
    int          val_dly;
    bit          junk;
    logic [15:0] offs;
    logic [7:0]  stuck;
    logic        exp_done;
    logic        exp_fail;
    logic [7:0]  exp_locked;
    logic [23:0] exp_slip;
    int          exp_reads;
  } vec_t;

  vec_t vecs [5];

  int total = 0;
  int bad   = 0;

  // IOB model: each lane's current rotation, advanced by every CALIB pulse.
  logic [1:0]   off [W];
  logic [W-1:0] stuck;
  logic         prev_req;
  logic [W-1:0] prev_calib;
  int           req_rises;

  // Reference model of the lane state.
  int           m_match [W];
  int           m_slip  [W];
  logic [W-1:0] m_locked;
  logic [W-1:0] sb_q [$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge PCLK);
    if (rd_req_o && !prev_req) req_rises++;
    prev_req = rd_req_o;
    if (calib_o != '0) check("calib_back_to_back", 32'(calib_o & prev_calib), 32'd0);
    for (int n = 0; n < W; n++)
      if (calib_o[n]) off[n] = off[n] + 2'd1;
    prev_calib = calib_o;
  endtask

  function automatic logic [3:0] lane_nib(input int n);
    logic [7:0] d;
    if (stuck[n]) return 4'hF;
    d = {EXP, EXP} << off[n];
    return d[7:4];
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"},   32'(done_o),     32'd0);
    check({tag, "_fail"},   32'(fail_o),     32'd0);
    check({tag, "_busy"},   32'(busy_o),     32'd0);
    check({tag, "_req"},    32'(rd_req_o),   32'd0);
    check({tag, "_calib"},  32'(calib_o),    32'd0);
    check({tag, "_locked"}, 32'(locked_o),   32'd0);
    check({tag, "_slip"},   32'(slip_cnt_o), 32'd0);
  endtask

  task automatic start_and_wait_req(output int lat);
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    check("done_clear_on_start", 32'(done_o), 32'd0);
    check("fail_clear_on_start", 32'(fail_o), 32'd0);
    lat = 1;
    while (!rd_req_o && lat < 20) begin
      tick;
      lat++;
    end
  endtask

  task automatic run_training(input int ack_dly, input int val_dly, input bit junk, output int reads);
    int lat, hi, guard;
    logic [W-1:0] mark, expc, acc;
    bit lim, stop;
    reads = 0;
    req_rises = 0;
    m_locked = '0;
    for (int n = 0; n < W; n++) begin
      m_match[n] = 0;
      m_slip[n]  = 0;
    end
    start_and_wait_req(lat);
    check("start_to_req_latency", lat, 2);
    stop = 0;
    for (int r = 0; r < 40 && !stop; r++) begin
      guard = 0;
      while (!rd_req_o && !done_o && !fail_o && guard < 40) begin
        tick;
        guard++;
      end
      if (done_o || fail_o) begin
        stop = 1;
      end else if (!rd_req_o) begin
        check("req_wait_bound", 32'(rd_req_o), 32'd1);
        stop = 1;
      end else begin
        hi = 0;
        for (int i = 0; i < ack_dly; i++) begin
          if (rd_req_o) hi++;
          tick;
        end
        if (ack_dly > 0) check("req_held_until_ack", hi, ack_dly);
        rd_ack_i = 1'b1;
        if (junk) begin
          rd_valid_i = 1'b1;
          rd_data_i  = '1;
        end
        tick;
        rd_ack_i   = 1'b0;
        rd_valid_i = 1'b0;
        rd_data_i  = '0;
        check("req_drop_after_ack", 32'(rd_req_o), 32'd0);
        for (int i = 0; i < val_dly; i++) tick;
        // Drive the beat and push the expected CALIB vector for it.
        mark = '0;
        for (int n = 0; n < W; n++) begin
          rd_data_i[4*n +: 4] = lane_nib(n);
          if (!m_locked[n]) begin
            if (lane_nib(n) == EXP) begin
              m_match[n]++;
              if (m_match[n] == MATCHES) m_locked[n] = 1'b1;
            end else begin
              m_match[n] = 0;
              mark[n] = 1'b1;
            end
          end
        end
        expc = '0;
        if (!(&m_locked)) begin
          lim = 0;
          for (int n = 0; n < W; n++)
            if (mark[n] && m_slip[n] == SLIPS) lim = 1;
          if (!lim) begin
            expc = mark;
            for (int n = 0; n < W; n++)
              if (mark[n]) m_slip[n]++;
          end
        end
        sb_q.push_back(expc);
        rd_valid_i = 1'b1;
        reads++;
        tick;
        rd_valid_i = 1'b0;
        rd_data_i  = '0;
        acc = '0;
        for (int i = 0; i < 3; i++) begin
          tick;
          acc |= calib_o;
        end
        check("calib_lanes", 32'(acc), 32'(sb_q.pop_front()));
        check("locked_track", 32'(locked_o), 32'(m_locked));
      end
    end
  endtask

  initial begin
    int reads, lat, k;
    vecs[0] = '{"aligned",    0, 0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 8'hFF, 24'h000000, 3};
    vecs[1] = '{"skew_lane2", 0, 2, 1'b0, 16'h0010, 8'h00, 1'b1, 1'b0, 8'hFF, 24'h0000C0, 6};
    vecs[2] = '{"stuck_lane5",0, 1, 1'b0, 16'h0000, 8'h20, 1'b0, 1'b1, 8'hDF, 24'h020000, 5};
    vecs[3] = '{"ack_delay10",10,0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 8'hFF, 24'h000000, 3};
    vecs[4] = '{"mixed_junk", 3, 5, 1'b1, 16'h8003, 8'h00, 1'b1, 1'b0, 8'hFF, 24'h400001, 5};

    RESET = 1'b1; start_i = 1'b0; rd_ack_i = 1'b0; rd_valid_i = 1'b0; rd_data_i = '0;
    stuck = '0; prev_req = 1'b0; prev_calib = '0; req_rises = 0;
    for (int n = 0; n < W; n++) off[n] = 2'd0;
    tick; tick; tick;
    RESET = 1'b0;
    tick;
    check_reset_outputs("reset");

    foreach (vecs[i]) begin
      for (int n = 0; n < W; n++) off[n] = vecs[i].offs[2*n +: 2];
      stuck = vecs[i].stuck;
      run_training(vecs[i].ack_dly, vecs[i].val_dly, vecs[i].junk, reads);
      check({vecs[i].name, "_done"},   32'(done_o),     32'(vecs[i].exp_done));
      check({vecs[i].name, "_fail"},   32'(fail_o),     32'(vecs[i].exp_fail));
      check({vecs[i].name, "_locked"}, 32'(locked_o),   32'(vecs[i].exp_locked));
      check({vecs[i].name, "_slip"},   32'(slip_cnt_o), 32'(vecs[i].exp_slip));
      check({vecs[i].name, "_busy"},   32'(busy_o),     32'd0);
      check({vecs[i].name, "_reads"},  reads,           vecs[i].exp_reads);
      check({vecs[i].name, "_one_req_per_read"}, req_rises, vecs[i].exp_reads);
    end

    // Timeout: ack a read, never return the beat.
    stuck = '0;
    for (int n = 0; n < W; n++) off[n] = 2'd0;
    start_and_wait_req(lat);
    rd_ack_i = 1'b1;
    tick;
    rd_ack_i = 1'b0;
    k = 0;
    while (!fail_o && k < 100) begin
      tick;
      k++;
    end
    check("timeout_cycles", k, 64);
    check("timeout_fail", 32'(fail_o), 32'd1);
    check("timeout_busy", 32'(busy_o), 32'd0);
    check("timeout_done", 32'(done_o), 32'd0);

    // Reset in the middle of SETTLE, then a clean restart.
    off[2] = 2'd1;
    start_and_wait_req(lat);
    rd_ack_i = 1'b1;
    tick;
    rd_ack_i = 1'b0;
    for (int n = 0; n < W; n++) rd_data_i[4*n +: 4] = lane_nib(n);
    rd_valid_i = 1'b1;
    tick;
    rd_valid_i = 1'b0;
    rd_data_i  = '0;
    k = 0;
    while (calib_o == '0 && k < 5) begin
      tick;
      k++;
    end
    check("settle_seq_calib", 32'(calib_o), 32'h04);
    tick; tick; tick;
    check("settle_seq_busy", 32'(busy_o), 32'd1);
    RESET = 1'b1;
    tick;
    RESET = 1'b0;
    check_reset_outputs("mid_settle_reset");
    for (int i = 0; i < 12; i++) begin
      tick;
      check("post_reset_quiet", 32'({calib_o, busy_o, rd_req_o}), 32'd0);
    end
    // Lane 2 took one slip before the reset, so two more are needed now.
    run_training(0, 0, 1'b0, reads);
    check("restart_done",   32'(done_o),     32'd1);
    check("restart_locked", 32'(locked_o),   32'hFF);
    check("restart_slip",   32'(slip_cnt_o), 32'h000080);
    check("restart_reads",  reads,           5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
